debug_unit: RTL and testbench

Command-driven sequencer between the UART FIFOs and the pipelined core. It loads programs into instruction memory, starts and stops execution, single-steps the core and dumps the register file back to the host. It owns the pipeline clock-enable and the reset pulse, so the core never runs while a program is being written.

---
 rtl/dbg_pkg.sv | 31 +++
 rtl/word_assembler.sv | 38 +++
 rtl/debug_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_debug_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// dbg_pkg
// Shared constants for the debug unit.
//   - Host command bytes:  'L' load, 'R' run, 'S' step, 'D' dump.
//   - Reply bytes sent back to the host: 'K' ack, 'H' halted, 'E' error.
//   - Sequencer state encoding.
//   - WORD_W: width of one instruction / register word.
package dbg_pkg;

    localparam int WORD_W = 32;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_DUMP  = 8'h44;

    localparam logic [7:0] RPL_ACK   = 8'h4B;
    localparam logic [7:0] RPL_HALT  = 8'h48;
    localparam logic [7:0] RPL_ERR   = 8'h45;

    typedef enum logic [2:0] {
        IDLE,
        LD_CNT,
        LD_BYTE,
        LD_WR,
        RUN,
        STEP,
        DUMP,
        SEND
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// word_assembler
// Collects four bytes, least-significant first, into one 32-bit word.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   clear        drop any partial word (start of a new load)
//   byte_valid   byte_in is consumed this cycle
//   byte_in      incoming byte
//   word         assembled word (valid the cycle after word_done)
//   word_done    this byte completes a word
module word_assembler
    import dbg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    logic [1:0] count;

    // New bytes enter at the top and shift down, so after four bytes the
    // first one received sits in bits [7:0].
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word  <= '0;
            count <= '0;
        end else if (byte_valid) begin
            word  <= {byte_in, word[WORD_W-1:8]};
            count <= count + 2'd1;
        end
    end

    assign word_done = byte_valid && (count == 2'd3);

endmodule

// File: rtl/debug_unit.sv
// debug_unit
// Command sequencer between the UART FIFOs and the pipelined core: loads
// instruction memory, runs / steps the core and (optionally) dumps the
// register file. It owns cpu_en and cpu_rst so the core is frozen while
// a program is being written.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rx_data/rx_empty/rx_rd   show-ahead RX FIFO head, empty flag, pop
//   tx_data/tx_full/tx_wr    TX FIFO byte, full flag, push
//   imem_we/imem_addr/imem_wdata   instruction-memory write port
//   cpu_en, cpu_rst       core advance enable, one-cycle core reset
//   halt                  core reports a decoded halt instruction
//   rf_dbg_addr/rf_dbg_data  register-file debug read port
//   busy                  sequencer is not idle
// Build option: define DEBUG_DUMP_EN to implement the 'D' dump command;
// without it 'D' is answered with 'E' and rf_dbg_addr is tied to 0.
module debug_unit
    import dbg_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int IMEM_AW = 8,
    parameter int REG_AW  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  rx_data,
    input  logic               rx_empty,
    output logic               rx_rd,
    output logic [DATA_W-1:0]  tx_data,
    input  logic               tx_full,
    output logic               tx_wr,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [WORD_W-1:0]  imem_wdata,
    output logic               cpu_en,
    output logic               cpu_rst,
    input  logic               halt,
    output logic [REG_AW-1:0]  rf_dbg_addr,
    input  logic [WORD_W-1:0]  rf_dbg_data,
    output logic               busy
);

    state_t             state, state_next;
    logic [7:0]         word_cnt, word_cnt_next;
    logic [IMEM_AW-1:0] addr_q, addr_next;
    logic [7:0]         reply_q, reply_next;

    logic               asm_clear;
    logic               asm_valid;
    logic               word_done;
    logic [WORD_W-1:0]  asm_word;

`ifdef DEBUG_DUMP_EN
    logic [REG_AW-1:0]  reg_idx, reg_idx_next;
    logic [1:0]         byte_idx, byte_idx_next;
`else
    logic               unused_rf_dbg_data;
    assign unused_rf_dbg_data = ^rf_dbg_data;
`endif

    word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_in    (rx_data[7:0]),
        .word       (asm_word),
        .word_done  (word_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            word_cnt <= '0;
            addr_q   <= '0;
            reply_q  <= '0;
`ifdef DEBUG_DUMP_EN
            reg_idx  <= '0;
            byte_idx <= '0;
`endif
        end else begin
            state    <= state_next;
            word_cnt <= word_cnt_next;
            addr_q   <= addr_next;
            reply_q  <= reply_next;
`ifdef DEBUG_DUMP_EN
            reg_idx  <= reg_idx_next;
            byte_idx <= byte_idx_next;
`endif
        end
    end

    // All strobes are suppressed while reset is sampled, so a reset in the
    // middle of RUN drops cpu_en in that very cycle rather than one later.
    always_comb begin
        state_next    = state;
        word_cnt_next = word_cnt;
        addr_next     = addr_q;
        reply_next    = reply_q;
        rx_rd         = 1'b0;
        tx_wr         = 1'b0;
        tx_data       = reply_q;
        imem_we       = 1'b0;
        cpu_en        = 1'b0;
        cpu_rst       = 1'b0;
        asm_clear     = 1'b0;
        asm_valid     = 1'b0;
`ifdef DEBUG_DUMP_EN
        reg_idx_next  = reg_idx;
        byte_idx_next = byte_idx;
`endif
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        rx_rd = 1'b1;
                        case (rx_data)
                            CMD_LOAD: begin
                                asm_clear  = 1'b1;
                                state_next = LD_CNT;
                            end
                            CMD_RUN:  state_next = RUN;
                            CMD_STEP: state_next = STEP;
`ifdef DEBUG_DUMP_EN
                            CMD_DUMP: begin
                                reg_idx_next  = '0;
                                byte_idx_next = '0;
                                state_next    = DUMP;
                            end
`endif
                            default: begin
                                reply_next = RPL_ERR;
                                state_next = SEND;
                            end
                        endcase
                    end
                end
                LD_CNT: begin
                    if (!rx_empty) begin
                        rx_rd         = 1'b1;
                        word_cnt_next = rx_data[7:0];
                        addr_next     = '0;
                        // An empty program still resets the core and is acked.
                        if (rx_data[7:0] == 8'd0) begin
                            cpu_rst    = 1'b1;
                            reply_next = RPL_ACK;
                            state_next = SEND;
                        end else begin
                            state_next = LD_BYTE;
                        end
                    end
                end
                LD_BYTE: begin
                    if (!rx_empty) begin
                        rx_rd     = 1'b1;
                        asm_valid = 1'b1;
                        if (word_done) begin
                            state_next = LD_WR;
                        end
                    end
                end
                LD_WR: begin
                    imem_we       = 1'b1;
                    addr_next     = addr_q + 1'b1;
                    word_cnt_next = word_cnt - 8'd1;
                    if (word_cnt == 8'd1) begin
                        cpu_rst    = 1'b1;
                        reply_next = RPL_ACK;
                        state_next = SEND;
                    end else begin
                        state_next = LD_BYTE;
                    end
                end
                RUN: begin
                    if (halt) begin
                        reply_next = RPL_HALT;
                        state_next = SEND;
                    end else begin
                        cpu_en = 1'b1;
                    end
                end
                STEP: begin
                    cpu_en     = 1'b1;
                    reply_next = RPL_ACK;
                    state_next = SEND;
                end
`ifdef DEBUG_DUMP_EN
                DUMP: begin
                    tx_data = rf_dbg_data[{byte_idx, 3'b000} +: 8];
                    if (!tx_full) begin
                        tx_wr         = 1'b1;
                        byte_idx_next = byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            reg_idx_next = reg_idx + 1'b1;
                            if (reg_idx == '1) begin
                                state_next = IDLE;
                            end
                        end
                    end
                end
`endif
                SEND: begin
                    if (!tx_full) begin
                        tx_wr      = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = asm_word;
    assign busy       = !reset && (state != IDLE);

`ifdef DEBUG_DUMP_EN
    assign rf_dbg_addr = reg_idx;
`else
    assign rf_dbg_addr = '0;
`endif

endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit
// Self-checking bench for debug_unit: a queue-modelled RX FIFO feeds
// commands, a scoreboard holds the expected TX bytes and memory writes,
// and a negedge monitor compares whatever the DUT produces.
module tb_debug_unit;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rx_rd;
    logic [7:0]  tx_data;
    logic        tx_full;
    logic        tx_wr;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_en;
    logic        cpu_rst;
    logic        halt;
    logic [4:0]  rf_dbg_addr;
    logic [31:0] rf_dbg_data;
    logic        busy;

    debug_unit #(.DATA_W(8), .IMEM_AW(8), .REG_AW(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_empty    (rx_empty),
        .rx_rd       (rx_rd),
        .tx_data     (tx_data),
        .tx_full     (tx_full),
        .tx_wr       (tx_wr),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_en      (cpu_en),
        .cpu_rst     (cpu_rst),
        .halt        (halt),
        .rf_dbg_addr (rf_dbg_addr),
        .rf_dbg_data (rf_dbg_data),
        .busy        (busy)
    );

    // Register file model: only r1 holds data.
    assign rf_dbg_data = (rf_dbg_addr == 5'd1) ? 32'h12345678 : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    int          enCount  = 0;
    int          rstCount = 0;
    int          wrCount  = 0;
    int          txCount  = 0;
    int          txCyc    = 0;
    int          haltCyc  = 0;
    bit          rdSeen   = 1'b0;
    bit          fullMode = 1'b0;

    logic [7:0]  rxQ[$];
    logic [7:0]  expTx[$];
    logic [7:0]  expAddr[$];
    logic [31:0] expData[$];

    typedef struct {
        logic [7:0] cmd;
        int         haltDelay;
        logic [7:0] expReply;
        int         expEn;
        bit         full;
        string      name;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic refreshRx();
        rx_empty = (rxQ.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rxQ[0];
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        rxQ.push_back(b);
        refreshRx();
    endtask

    task automatic waitPop(input int maxCycles);
        int n = 0;
        while (rxQ.size() != 0 && n < maxCycles) begin
            @(posedge clk); #2;
            n++;
        end
        if (rxQ.size() != 0) checkOutput("rx_drain_timeout", 32'(rxQ.size()), 0);
    endtask

    task automatic waitIdle(input int maxCycles);
        int n = 0;
        while ((busy || expTx.size() != 0 || rxQ.size() != 0) && n < maxCycles) begin
            @(posedge clk); #2;
            n++;
        end
        if (busy || expTx.size() != 0 || rxQ.size() != 0)
            checkOutput("idle_timeout", 32'(expTx.size()), 0);
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // RX FIFO pop lands just after the edge that consumed the byte.
    always @(posedge clk) begin
        #1;
        if (rdSeen) begin
            if (rxQ.size() > 0) void'(rxQ.pop_front());
            refreshRx();
        end
    end

    always @(posedge clk) begin
        #2;
        tx_full = fullMode ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    always @(negedge clk) begin
        rdSeen = rx_rd;
        if (rx_rd && rx_empty) checkOutput("rx_rd_while_empty", 1, 0);
        if (cpu_en) enCount++;
        if (cpu_rst) rstCount++;
        if (cpu_en && imem_we) checkOutput("en_we_overlap", 1, 0);
        if (imem_we) begin
            wrCount++;
            if (expAddr.size() == 0) begin
                checkOutput("imem_unexpected", imem_wdata, 0);
            end else begin
                checkOutput("imem_addr", 32'(imem_addr), 32'(expAddr.pop_front()));
                checkOutput("imem_wdata", imem_wdata, expData.pop_front());
            end
        end
        if (tx_wr) begin
            txCount++;
            txCyc = cycle;
            if (tx_full) checkOutput("tx_wr_while_full", 1, 0);
            if (expTx.size() == 0) checkOutput("tx_unexpected", 32'(tx_data), 32'hFFFF);
            else checkOutput("tx_data", 32'(tx_data), 32'(expTx.pop_front()));
        end
    end

    initial begin
        vec_t       vecs[8];
        int         nVec;
        logic [7:0] seq[10];

        reset = 1'b1;
        halt  = 1'b0;
        tx_full = 1'b0;
        refreshRx();
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        @(negedge clk);
        checkOutput("rst_busy",        32'(busy), 0);
        checkOutput("rst_cpu_en",      32'(cpu_en), 0);
        checkOutput("rst_cpu_rst",     32'(cpu_rst), 0);
        checkOutput("rst_imem_we",     32'(imem_we), 0);
        checkOutput("rst_tx_wr",       32'(tx_wr), 0);
        checkOutput("rst_rx_rd",       32'(rx_rd), 0);
        checkOutput("rst_imem_addr",   32'(imem_addr), 0);
        checkOutput("rst_imem_wdata",  imem_wdata, 0);
        checkOutput("rst_tx_data",     32'(tx_data), 0);
        checkOutput("rst_rf_dbg_addr", 32'(rf_dbg_addr), 0);
        @(posedge clk); #2;

        // Single-byte commands: reply byte and number of enabled cycles.
        vecs[0] = '{8'h53, -1, 8'h4B, 1,  1'b0, "step"};
        vecs[1] = '{8'h58, -1, 8'h45, 0,  1'b0, "unknown_X"};
        vecs[2] = '{8'h52, 10, 8'h48, 10, 1'b0, "run10"};
        vecs[3] = '{8'h52, 0,  8'h48, 0,  1'b0, "run_halt_entry"};
        vecs[4] = '{8'h52, 3,  8'h48, 3,  1'b1, "run3_full"};
        vecs[5] = '{8'h53, -1, 8'h4B, 1,  1'b1, "step_full"};
        vecs[6] = '{8'h00, -1, 8'h45, 0,  1'b0, "unknown_00"};
        nVec = 7;
`ifndef DEBUG_DUMP_EN
        vecs[7] = '{8'h44, -1, 8'h45, 0,  1'b0, "dump_disabled"};
        nVec = 8;
`endif
        for (int i = 0; i < nVec; i++) begin
            enCount  = 0;
            halt     = (vecs[i].haltDelay == 0);
            haltCyc  = cycle;
            fullMode = vecs[i].full;
            expTx.push_back(vecs[i].expReply);
            applyStimulus(vecs[i].cmd);
            waitPop(20);
            if (vecs[i].haltDelay > 0) begin
                repeat (vecs[i].haltDelay) begin
                    @(posedge clk); #2;
                end
                halt    = 1'b1;
                haltCyc = cycle;
            end
            waitIdle(200);
            checkOutput({vecs[i].name, "_en_cycles"}, 32'(enCount), 32'(vecs[i].expEn));
            if (vecs[i].haltDelay > 0 && !vecs[i].full)
                checkOutput({vecs[i].name, "_h_latency"}, 32'(txCyc - haltCyc), 1);
            halt     = 1'b0;
            fullMode = 1'b0;
            @(posedge clk); #2;
        end

        // Two-word load.
        rstCount = 0; wrCount = 0;
        expAddr.push_back(8'd0); expData.push_back(32'h00A00513);
        expAddr.push_back(8'd1); expData.push_back(32'h00100593);
        expTx.push_back(8'h4B);
        seq = '{8'h4C, 8'h02, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        for (int i = 0; i < 10; i++) applyStimulus(seq[i]);
        waitIdle(200);
        checkOutput("load2_cpu_rst", 32'(rstCount), 1);
        checkOutput("load2_writes", 32'(wrCount), 2);
        checkOutput("load2_next_addr", 32'(imem_addr), 2);

        // Empty load.
        rstCount = 0; wrCount = 0;
        expTx.push_back(8'h4B);
        applyStimulus(8'h4C); applyStimulus(8'h00);
        waitIdle(100);
        checkOutput("load0_cpu_rst", 32'(rstCount), 1);
        checkOutput("load0_writes", 32'(wrCount), 0);

        // Reset mid-RUN: cpu_en must fall in the reset cycle itself.
        applyStimulus(8'h52);
        waitPop(20);
        repeat (3) begin @(posedge clk); #2; end
        @(negedge clk);
        checkOutput("run_active_before_reset", 32'(cpu_en), 1);
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("cpu_en_in_reset", 32'(cpu_en), 0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("run_abort_busy", 32'(busy), 0);
        @(posedge clk); #2;

        // Reset after the fifth load byte: the first word is written, the
        // partial second word must not leak into the next load.
        expAddr.push_back(8'd0); expData.push_back(32'h00A00513);
        seq = '{8'h4C, 8'h02, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 7; i++) applyStimulus(seq[i]);
        waitPop(50);
        repeat (2) begin @(posedge clk); #2; end
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        rstCount = 0; wrCount = 0;
        expAddr.push_back(8'd0); expData.push_back(32'hDDCCBBAA);
        expTx.push_back(8'h4B);
        seq = '{8'h4C, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) applyStimulus(seq[i]);
        waitIdle(100);
        checkOutput("reload_cpu_rst", 32'(rstCount), 1);
        checkOutput("reload_writes", 32'(wrCount), 1);

`ifdef DEBUG_DUMP_EN
        // Register dump with back-pressure.
        begin
            logic [31:0] w;
            txCount = 0;
            for (int r = 0; r < 32; r++) begin
                w = (r == 1) ? 32'h12345678 : 32'h0;
                for (int b = 0; b < 4; b++) expTx.push_back(w[8*b +: 8]);
            end
            fullMode = 1'b1;
            applyStimulus(8'h44);
            waitIdle(2000);
            fullMode = 1'b0;
            checkOutput("dump_bytes", 32'(txCount), 128);
            checkOutput("dump_addr_wrap", 32'(rf_dbg_addr), 0);
        end
`endif

        repeat (3) begin @(posedge clk); #2; end
        checkOutput("tx_scoreboard_empty", 32'(expTx.size()), 0);
        checkOutput("imem_scoreboard_empty", 32'(expAddr.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
